contador_lector: RTL

Read-out initiator for the per-FIFO pop counter block. On a start request, and only while the system reports IDLE, it walks idx across all FIFO_UNITS counters using the req/idx/IDLE handshake. It captures each returned cuenta on valid, accumulates a total and flags non-responding indices. It sits between the top-level test/control logic and the counter, replacing hand-driven req/idx sequencing.

---
 rtl/contador_lector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/contador_lector.sv
// Read-out initiator for the per-FIFO pop counters: walks idx over every counter
// with a req/valid handshake, captures each cuenta, sums them and flags silent indices.
module contador_lector #(
   parameter int FIFO_UNITS = 4,
   parameter int INDEX      = 2,
   parameter int CNT_W      = 5,
   parameter int TIMEOUT    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        IDLE,
   input  logic                        valid,
   input  logic [CNT_W-1:0]            cuenta,
   output logic                        req,
   output logic [INDEX-1:0]            idx,
   output logic [FIFO_UNITS*CNT_W-1:0] conteos,
   output logic [CNT_W+INDEX-1:0]      total,
   output logic [FIFO_UNITS-1:0]       err,
   output logic                        busy,
   output logic                        done,
   output logic                        abort
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_REPOSO,
      ST_REQ,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tcnt;
   logic            expired;
   logic            last_idx;
   logic            launch;

   // expired marks the TIMEOUT-th request cycle; a valid in that same cycle still wins
   assign expired  = (tcnt == TW'(TIMEOUT - 1));
   assign last_idx = (idx == INDEX'(FIFO_UNITS - 1));
   assign launch   = start && IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_REPOSO;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_REPOSO: begin
            if (launch) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            req  = 1'b1;
            busy = 1'b1;
            if (!IDLE) begin
               state_nxt = ST_REPOSO;
            end else if (valid || expired) begin
               state_nxt = last_idx ? ST_DONE : ST_GAP;
            end
         end
         ST_GAP: begin
            busy = 1'b1;
            if (!IDLE) begin
               state_nxt = ST_REPOSO;
            end else begin
               state_nxt = ST_REQ;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_REPOSO;
         end
         default: begin
            state_nxt = ST_REPOSO;
         end
      endcase
   end

   // Datapath: captured slices, running sum, error flags, timeout counter, abort pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         conteos <= '0;
         total   <= '0;
         err     <= '0;
         tcnt    <= '0;
         abort   <= 1'b0;
      end else begin
         abort <= 1'b0;
         case (state)
            ST_REPOSO: begin
               tcnt <= '0;
               if (launch) begin
                  idx   <= '0;
                  total <= '0;
                  err   <= '0;
               end
            end
            ST_REQ: begin
               if (!IDLE) begin
                  abort <= 1'b1;
                  tcnt  <= '0;
               end else if (valid) begin
                  for (int i = 0; i < FIFO_UNITS; i++) begin
                     if (idx == INDEX'(i)) begin
                        conteos[i*CNT_W +: CNT_W] <= cuenta;
                     end
                  end
                  total <= total + {{INDEX{1'b0}}, cuenta};
                  tcnt  <= '0;
               end else if (expired) begin
                  for (int i = 0; i < FIFO_UNITS; i++) begin
                     if (idx == INDEX'(i)) begin
                        conteos[i*CNT_W +: CNT_W] <= '0;
                        err[i]                    <= 1'b1;
                     end
                  end
                  tcnt <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_GAP: begin
               tcnt <= '0;
               if (!IDLE) begin
                  abort <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               tcnt <= '0;
            end
         endcase
      end
   end

endmodule
